// File: rtl/ee354_project_dirq.sv
// ee354_project_dirq: direction input queue; define DIRQ_REVERSE_FILTER_EN to drop reversing presses
module ee354_project_dirq #(
  parameter int         DEPTH     = 4,
  parameter logic [1:0] INIT_DIRN = 2'b11
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       BtnU_SCEN,
  input  logic                       BtnD_SCEN,
  input  logic                       BtnL_SCEN,
  input  logic                       BtnR_SCEN,
  input  logic                       Speed_Clk,
  input  logic                       q_I,
  input  logic                       q_Run,
  output logic [1:0]                 Cur_Dirn,
  output logic                       Move_Pulse,
  output logic [$clog2(DEPTH):0]     Q_Count,
  output logic                       Overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t          state_q, state_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d, newest;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      cur_q, cur_d, press, ref_dirn;
  logic            pulse_q, pulse_d, ovf_q, ovf_d, spd_q, spd_d;
  logic            press_v, tick, run, full, pop, rev, cand, push;
  // next-state: game FSM tracking, press filtering, queue push/pop and tick strobe
  always_comb begin
    state_d  = q_I ? IDLE : q_Run ? RUN : HOLD;
    spd_d    = Speed_Clk;
    tick     = Speed_Clk & ~spd_q;
    run      = state_q == RUN;
    press_v  = BtnU_SCEN | BtnD_SCEN | BtnL_SCEN | BtnR_SCEN;
    press    = BtnU_SCEN ? 2'b00 : BtnD_SCEN ? 2'b01 : BtnL_SCEN ? 2'b10 : 2'b11;
    newest   = wr_q - 1'b1;
    ref_dirn = (cnt_q != '0) ? mem_q[newest] : cur_q;
`ifdef DIRQ_REVERSE_FILTER_EN
    rev      = (ref_dirn[1] == press[1]) && (ref_dirn[0] != press[0]);
`else
    rev      = 1'b0;
`endif
    full     = cnt_q == CW'(DEPTH);
    pop      = run & tick & (cnt_q != '0);
    cand     = run & press_v & (press != ref_dirn) & ~rev;
    push     = cand & (~full | pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_q] = press;
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    cur_d    = pop ? mem_q[rd_q] : cur_q;
    pulse_d  = run & tick;
    ovf_d    = ovf_q | (cand & full & ~pop);
    if (state_q == IDLE) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      cur_d = INIT_DIRN;
      ovf_d = 1'b0;
    end
  end
  // state registers; storage array needs no reset since pointers and count do
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
    if (!Reset_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      cur_q   <= INIT_DIRN;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
      spd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
      spd_q   <= spd_d;
    end
  end
  assign Cur_Dirn   = cur_q;
  assign Move_Pulse = pulse_q;
  assign Q_Count    = cnt_q;
  assign Overflow   = ovf_q;
endmodule

// File: tb/tb_ee354_project_dirq.sv
// tb_ee354_project_dirq: directed checks of the direction queue
module tb_ee354_project_dirq;
  logic       Clk = 0, Reset_n = 0;
  logic       BtnU_SCEN = 0, BtnD_SCEN = 0, BtnL_SCEN = 0, BtnR_SCEN = 0;
  logic       Speed_Clk = 0, q_I = 1, q_Run = 0;
  logic [1:0] Cur_Dirn;
  logic       Move_Pulse, Overflow;
  logic [2:0] Q_Count;
  int         errors = 0, checks = 0;
  logic [1:0] ov_cur [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
  logic [1:0] fp_cur [4] = '{2'd2, 2'd1, 2'd3, 2'd0};

  ee354_project_dirq #(.DEPTH(4), .INIT_DIRN(2'b11)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .BtnU_SCEN(BtnU_SCEN), .BtnD_SCEN(BtnD_SCEN), .BtnL_SCEN(BtnL_SCEN), .BtnR_SCEN(BtnR_SCEN),
    .Speed_Clk(Speed_Clk), .q_I(q_I), .q_Run(q_Run),
    .Cur_Dirn(Cur_Dirn), .Move_Pulse(Move_Pulse), .Q_Count(Q_Count), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [1:0] d);
    BtnU_SCEN = (d == 2'd0);
    BtnD_SCEN = (d == 2'd1);
    BtnL_SCEN = (d == 2'd2);
    BtnR_SCEN = (d == 2'd3);
    cyc(1);
    {BtnU_SCEN, BtnD_SCEN, BtnL_SCEN, BtnR_SCEN} = 4'b0;
  endtask

  task automatic tick_start;
    Speed_Clk = 1;
    cyc(1);
  endtask

  task automatic tick_end;
    Speed_Clk = 0;
    cyc(1);
  endtask

  task automatic idle_run;
    q_I = 1;
    q_Run = 0;
    cyc(2);
    q_I = 0;
    q_Run = 1;
    cyc(1);
  endtask

  task automatic test_reset;
    Reset_n = 0;
    q_I = 1;
    cyc(3);
    checks++; if (Cur_Dirn !== 2'b11) begin errors++; $display("FAIL reset_cur got %b exp 11", Cur_Dirn); end
    checks++; if (Q_Count !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", Q_Count); end
    checks++; if (Move_Pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", Move_Pulse); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", Overflow); end
    Reset_n = 1;
    cyc(2);
    checks++; if (Cur_Dirn !== 2'b11 || Q_Count !== 3'd0) begin errors++; $display("FAIL idle_state got cur=%b cnt=%0d exp cur=11 cnt=0", Cur_Dirn, Q_Count); end
  endtask

  task automatic test_two_turns;
    q_I = 0;
    q_Run = 1;
    cyc(1);
    press(2'd0);
    press(2'd2);
    checks++; if (Q_Count !== 3'd2) begin errors++; $display("FAIL turns_cnt got %0d exp 2", Q_Count); end
    tick_start;
    checks++; if (Cur_Dirn !== 2'b00 || Move_Pulse !== 1'b1 || Q_Count !== 3'd1) begin errors++; $display("FAIL turns_tick1 got cur=%b pulse=%b cnt=%0d exp cur=00 pulse=1 cnt=1", Cur_Dirn, Move_Pulse, Q_Count); end
    tick_end;
    checks++; if (Move_Pulse !== 1'b0) begin errors++; $display("FAIL turns_pulse_once got %b exp 0", Move_Pulse); end
    tick_start;
    checks++; if (Cur_Dirn !== 2'b10 || Move_Pulse !== 1'b1 || Q_Count !== 3'd0) begin errors++; $display("FAIL turns_tick2 got cur=%b pulse=%b cnt=%0d exp cur=10 pulse=1 cnt=0", Cur_Dirn, Move_Pulse, Q_Count); end
    tick_end;
  endtask

  task automatic test_reverse;
    logic [2:0] exp_cnt;
    logic [1:0] exp_cur;
`ifdef DIRQ_REVERSE_FILTER_EN
    exp_cnt = 3'd0;
    exp_cur = 2'b11;
`else
    exp_cnt = 3'd1;
    exp_cur = 2'b10;
`endif
    idle_run;
    checks++; if (Cur_Dirn !== 2'b11) begin errors++; $display("FAIL rev_idle_cur got %b exp 11", Cur_Dirn); end
    press(2'd3);
    checks++; if (Q_Count !== 3'd0) begin errors++; $display("FAIL dup_drop got %0d exp 0", Q_Count); end
    press(2'd2);
    checks++; if (Q_Count !== exp_cnt) begin errors++; $display("FAIL rev_cnt got %0d exp %0d", Q_Count, exp_cnt); end
    tick_start;
    checks++; if (Cur_Dirn !== exp_cur || Q_Count !== 3'd0 || Move_Pulse !== 1'b1) begin errors++; $display("FAIL rev_tick got cur=%b cnt=%0d pulse=%b exp cur=%b cnt=0 pulse=1", Cur_Dirn, Q_Count, Move_Pulse, exp_cur); end
    tick_end;
  endtask

  task automatic test_overflow;
    idle_run;
    press(2'd0);
    press(2'd2);
    press(2'd1);
    press(2'd3);
    checks++; if (Q_Count !== 3'd4 || Overflow !== 1'b0) begin errors++; $display("FAIL ovf_fill got cnt=%0d ovf=%b exp cnt=4 ovf=0", Q_Count, Overflow); end
    press(2'd0);
    checks++; if (Q_Count !== 3'd4 || Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got cnt=%0d ovf=%b exp cnt=4 ovf=1", Q_Count, Overflow); end
    for (int i = 0; i < 4; i++) begin
      tick_start;
      checks++; if (Cur_Dirn !== ov_cur[i] || Q_Count !== 3'(3 - i)) begin errors++; $display("FAIL ovf_pop%0d got cur=%b cnt=%0d exp cur=%b cnt=%0d", i, Cur_Dirn, Q_Count, ov_cur[i], 3 - i); end
      tick_end;
    end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", Overflow); end
  endtask

  task automatic test_push_pop;
    idle_run;
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL idle_clears_ovf got %b exp 0", Overflow); end
    press(2'd0);
    BtnL_SCEN = 1;
    Speed_Clk = 1;
    cyc(1);
    BtnL_SCEN = 0;
    checks++; if (Cur_Dirn !== 2'b00 || Q_Count !== 3'd1 || Move_Pulse !== 1'b1) begin errors++; $display("FAIL pushpop got cur=%b cnt=%0d pulse=%b exp cur=00 cnt=1 pulse=1", Cur_Dirn, Q_Count, Move_Pulse); end
    tick_end;
    tick_start;
    checks++; if (Cur_Dirn !== 2'b10 || Q_Count !== 3'd0) begin errors++; $display("FAIL pushpop_next got cur=%b cnt=%0d exp cur=10 cnt=0", Cur_Dirn, Q_Count); end
    tick_end;
  endtask

  task automatic test_full_pop;
    idle_run;
    press(2'd0);
    press(2'd2);
    press(2'd1);
    press(2'd3);
    BtnU_SCEN = 1;
    Speed_Clk = 1;
    cyc(1);
    BtnU_SCEN = 0;
    checks++; if (Cur_Dirn !== 2'b00 || Q_Count !== 3'd4 || Overflow !== 1'b0) begin errors++; $display("FAIL full_pop got cur=%b cnt=%0d ovf=%b exp cur=00 cnt=4 ovf=0", Cur_Dirn, Q_Count, Overflow); end
    tick_end;
    for (int i = 0; i < 4; i++) begin
      tick_start;
      checks++; if (Cur_Dirn !== fp_cur[i] || Q_Count !== 3'(3 - i)) begin errors++; $display("FAIL wrap_pop%0d got cur=%b cnt=%0d exp cur=%b cnt=%0d", i, Cur_Dirn, Q_Count, fp_cur[i], 3 - i); end
      tick_end;
    end
  endtask

  task automatic test_hold;
    press(2'd2);
    tick_start;
    tick_end;
    BtnU_SCEN = 1;
    BtnR_SCEN = 1;
    cyc(1);
    BtnU_SCEN = 0;
    BtnR_SCEN = 0;
    checks++; if (Q_Count !== 3'd1) begin errors++; $display("FAIL prio_cnt got %0d exp 1", Q_Count); end
    press(2'd0);
    checks++; if (Q_Count !== 3'd1) begin errors++; $display("FAIL prio_newest_up got cnt=%0d exp 1", Q_Count); end
    q_Run = 0;
    cyc(1);
    tick_start;
    checks++; if (Move_Pulse !== 1'b0 || Q_Count !== 3'd1 || Cur_Dirn !== 2'b10) begin errors++; $display("FAIL hold_freeze got pulse=%b cnt=%0d cur=%b exp pulse=0 cnt=1 cur=10", Move_Pulse, Q_Count, Cur_Dirn); end
    tick_end;
    press(2'd1);
    checks++; if (Q_Count !== 3'd1) begin errors++; $display("FAIL hold_press got %0d exp 1", Q_Count); end
    q_I = 1;
    cyc(2);
    checks++; if (Q_Count !== 3'd0 || Cur_Dirn !== 2'b11) begin errors++; $display("FAIL hold_to_idle got cnt=%0d cur=%b exp cnt=0 cur=11", Q_Count, Cur_Dirn); end
  endtask

  task automatic test_leave_run;
    q_I = 0;
    q_Run = 1;
    cyc(1);
    press(2'd0);
    Speed_Clk = 1;
    q_Run = 0;
    cyc(1);
    checks++; if (Move_Pulse !== 1'b1 || Cur_Dirn !== 2'b00 || Q_Count !== 3'd0) begin errors++; $display("FAIL leave_run got pulse=%b cur=%b cnt=%0d exp pulse=1 cur=00 cnt=0", Move_Pulse, Cur_Dirn, Q_Count); end
    tick_end;
    checks++; if (Move_Pulse !== 1'b0) begin errors++; $display("FAIL leave_run_once got %b exp 0", Move_Pulse); end
  endtask

  task automatic test_reset_mid;
    q_Run = 1;
    cyc(1);
    press(2'd2);
    Speed_Clk = 1;
    Reset_n = 0;
    cyc(1);
    checks++; if (Move_Pulse !== 1'b0 || Q_Count !== 3'd0 || Cur_Dirn !== 2'b11 || Overflow !== 1'b0) begin errors++; $display("FAIL reset_mid got pulse=%b cnt=%0d cur=%b ovf=%b exp pulse=0 cnt=0 cur=11 ovf=0", Move_Pulse, Q_Count, Cur_Dirn, Overflow); end
    Reset_n = 1;
    Speed_Clk = 0;
    cyc(1);
    checks++; if (Move_Pulse !== 1'b0) begin errors++; $display("FAIL reset_mid_pulse got %b exp 0", Move_Pulse); end
  endtask

  initial begin
    test_reset;
    test_two_turns;
    test_reverse;
    test_overflow;
    test_push_pop;
    test_full_pop;
    test_hold;
    test_leave_run;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
